// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared frame layout, command codes and FSM states for the SPI frame controller
package spi_ctrl_pkg;

  localparam int CMD_MSB  = 31;
  localparam int CMD_LSB  = 28;
  localparam int ADDR_MSB = 27;
  localparam int ADDR_LSB = 24;
  localparam int DATA_MSB = 23;
  localparam int DATA_LSB = 0;

  typedef enum logic [CMD_MSB-CMD_LSB:0] {
    CMD_WRITE  = 4'h1,
    CMD_COMMIT = 4'h2
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WRITE,
    ST_COMMIT
  } state_e;

  typedef struct packed {
    cmd_e                           cmd;
    logic [ADDR_MSB-ADDR_LSB:0]     addr;
    logic [DATA_MSB-DATA_LSB:0]     data;
  } frame_t;

endpackage

// File: rtl/spi_frame_shifter.sv
// rtl/spi_frame_shifter.sv - MSB-first bit assembler with abort and optional idle timeout
// Idle timeout is built only when SPI_FRAME_TIMEOUT_EN is defined.
module spi_frame_shifter #(
  parameter int FRAME_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_bit,
  input  logic                   i_bit_en,
  input  logic                   i_abort,
  output logic                   o_word_valid,
  output logic [FRAME_WIDTH-1:0] o_word,
  output logic                   o_partial,
  output logic                   o_error
);

  localparam int CNT_W = $clog2(FRAME_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_WIDTH - 1);

  logic [FRAME_WIDTH-2:0] r_shift;
  logic [CNT_W-1:0]       r_count;
  logic [FRAME_WIDTH-1:0] w_next;
  logic                   w_timeout;
  logic                   w_drop;

`ifdef SPI_FRAME_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;

  // Counts idle cycles only while a frame is partially received.
  always_ff @(posedge clk) begin
    if (reset || i_bit_en || i_abort || w_timeout || (r_count == '0)) r_tmo <= '0;
    else                                                               r_tmo <= r_tmo + 1'b1;
  end

  assign w_timeout = (r_count != '0) && !i_bit_en && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_range
  end
  assign w_timeout = 1'b0;
`endif

  assign w_drop       = i_abort || w_timeout;
  assign w_next       = {r_shift, i_bit};
  assign o_word       = w_next;
  assign o_word_valid = i_bit_en && !w_drop && (r_count == LAST_BIT);
  assign o_partial    = (r_count != '0);
  assign o_error      = w_drop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (reset || w_drop) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_bit_en) begin
      r_shift <= w_next[FRAME_WIDTH-2:0];
      r_count <= (r_count == LAST_BIT) ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/spi_frame_controller.sv
// rtl/spi_frame_controller.sv - decodes SPI frames into config-bus writes and commit pulses
// Optional idle timeout of partial frames: define SPI_FRAME_TIMEOUT_EN.
module spi_frame_controller
  import spi_ctrl_pkg::*;
#(
  parameter int FRAME_WIDTH    = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serialOut,
  input  logic                  serialEn,
  input  logic                  frameAbort,
  output logic [ADDR_WIDTH-1:0] cfgAddr,
  output logic [DATA_WIDTH-1:0] cfgData,
  output logic                  cfgValid,
  input  logic                  cfgReady,
  output logic                  commitPulse,
  output logic                  busy,
  output logic [7:0]            errorCount
);

  logic                   w_word_valid;
  logic [FRAME_WIDTH-1:0] w_word;
  logic                   w_partial;
  logic                   w_shift_err;
  logic                   w_overrun;
  logic                   w_bad_cmd;
  logic                   w_err;

  frame_t                 r_hold;
  logic                   r_hold_valid;
  state_e                 r_state;
  logic [ADDR_WIDTH-1:0]  r_cfg_addr;
  logic [DATA_WIDTH-1:0]  r_cfg_data;
  logic                   r_cfg_valid;
  logic                   r_commit;
  logic [7:0]             r_err_cnt;

  spi_frame_shifter #(
    .FRAME_WIDTH   (FRAME_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_shifter (
    .clk         (clk),
    .reset       (reset),
    .i_bit       (serialOut),
    .i_bit_en    (serialEn),
    .i_abort     (frameAbort),
    .o_word_valid(w_word_valid),
    .o_word      (w_word),
    .o_partial   (w_partial),
    .o_error     (w_shift_err)
  );

  assign w_overrun = w_word_valid && r_hold_valid;
  assign w_bad_cmd = (r_state == ST_DECODE) && (r_hold.cmd != CMD_WRITE) && (r_hold.cmd != CMD_COMMIT);
  // Simultaneous error sources collapse into a single increment.
  assign w_err     = w_shift_err || w_overrun || w_bad_cmd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_state      <= ST_IDLE;
      r_cfg_addr   <= '0;
      r_cfg_data   <= '0;
      r_cfg_valid  <= 1'b0;
      r_commit     <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;

      if (w_word_valid && !r_hold_valid) begin
        r_hold       <= frame_t'(w_word);
        r_hold_valid <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_hold_valid) r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          case (r_hold.cmd)
            CMD_WRITE: begin
              r_cfg_addr  <= r_hold.addr;
              r_cfg_data  <= r_hold.data;
              r_cfg_valid <= 1'b1;
              r_state     <= ST_WRITE;
            end
            CMD_COMMIT: begin
              r_commit <= 1'b1;
              r_state  <= ST_COMMIT;
            end
            default: begin
              r_hold_valid <= 1'b0;
              r_state      <= ST_IDLE;
            end
          endcase
        end
        ST_WRITE: begin
          if (cfgReady) begin
            r_cfg_valid  <= 1'b0;
            r_hold_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        ST_COMMIT: begin
          r_commit     <= 1'b0;
          r_hold_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfgAddr     = r_cfg_addr;
  assign cfgData     = r_cfg_data;
  assign cfgValid    = r_cfg_valid;
  assign commitPulse = r_commit;
  assign errorCount  = r_err_cnt;
  assign busy        = w_partial || r_hold_valid || (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_frame_controller.sv
// tb/tb_spi_frame_controller.sv - randomized self-checking bench for spi_frame_controller
// Timeout expectations follow SPI_FRAME_TIMEOUT_EN.
module tb_spi_frame_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        serialOut;
  logic        serialEn;
  logic        frameAbort;
  logic        cfgReady;
  logic [3:0]  cfgAddr;
  logic [23:0] cfgData;
  logic        cfgValid;
  logic        commitPulse;
  logic        busy;
  logic [7:0]  errorCount;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int last_strobe_cyc = 0;
  int v_rise_cyc = -100;
  int v_run = 0, v_max = 0;
  int c_run = 0, c_max = 0;
  int stab_viol = 0;
  int obs_commits = 0;
  logic [27:0] obs_w[$];
  logic        prev_v = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [27:0] prev_ad = '0;

  logic [27:0] exp_w[$];
  int exp_commits = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  spi_frame_controller dut (
    .clk        (clk),
    .reset      (reset),
    .serialOut  (serialOut),
    .serialEn   (serialEn),
    .frameAbort (frameAbort),
    .cfgAddr    (cfgAddr),
    .cfgData    (cfgData),
    .cfgValid   (cfgValid),
    .cfgReady   (cfgReady),
    .commitPulse(commitPulse),
    .busy       (busy),
    .errorCount (errorCount)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (cfgValid && cfgReady) obs_w.push_back({cfgAddr, cfgData});
      if (cfgValid && !prev_v) v_rise_cyc = cyc;
      if (cfgValid) begin v_run++; if (v_run > v_max) v_max = v_run; end else v_run = 0;
      if (commitPulse) begin
        obs_commits++;
        c_run++;
        if (c_run > c_max) c_max = c_run;
      end else c_run = 0;
      if (prev_v && cfgValid && !prev_rdy && ({cfgAddr, cfgData} != prev_ad)) stab_viol++;
    end
    prev_v   = cfgValid;
    prev_rdy = cfgReady;
    prev_ad  = {cfgAddr, cfgData};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void bump_err();
    if (exp_err < 255) exp_err++;
  endfunction

  // Reference: a frame arriving while a word is still pending is lost as an overrun.
  function automatic void model_frame(input logic [31:0] f, input bit pending);
    if (pending) bump_err();
    else begin
      case (f[31:28])
        4'h1:    exp_w.push_back(f[27:0]);
        4'h2:    exp_commits++;
        default: bump_err();
      endcase
    end
  endfunction

  task automatic compare_model(input string tag);
    check({tag, "_nwr"}, obs_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
      check({tag, "_wr"}, {4'h0, obs_w[i]}, {4'h0, exp_w[i]});
    check({tag, "_ncommit"}, obs_commits, exp_commits);
    check({tag, "_err"}, errorCount, exp_err);
    obs_w.delete();
    exp_w.delete();
  endtask

  task automatic send_bit(input logic b, input int gap);
    @(posedge clk); #1;
    serialEn  = 1'b1;
    serialOut = b;
    @(posedge clk); #1;
    serialEn  = 1'b0;
    last_strobe_cyc = cyc;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] f, input int gap);
    for (int i = 31; i >= 0; i--) send_bit(f[i], gap);
  endtask

  task automatic pulse_abort(input logic with_bit);
    @(posedge clk); #1;
    frameAbort = 1'b1;
    serialEn   = with_bit;
    serialOut  = 1'b1;
    @(posedge clk); #1;
    frameAbort = 1'b0;
    serialEn   = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (rnd) cfgReady = 1'($urandom_range(0, 1));
      if (!busy && !cfgValid) return;
    end
    check("wait_idle_busy", busy, 0);
  endtask

  initial begin
    logic [31:0] f;
    logic [31:0] rnd;
    logic [3:0]  cmd;

    reset = 1'b1; serialOut = 1'b0; serialEn = 1'b0; frameAbort = 1'b0; cfgReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", cfgAddr, 0);
    check("rst_data", cfgData, 0);
    check("rst_valid", cfgValid, 0);
    check("rst_commit", commitPulse, 0);
    check("rst_busy", busy, 0);
    check("rst_err", errorCount, 0);
    reset = 1'b0;

    // Basic write at SPI-like strobe spacing, consumer always ready.
    f = 32'h1A12_3456;
    send_frame(f, 11);
    model_frame(f, 0);
    wait_idle(0);
    check("latency", v_rise_cyc - last_strobe_cyc, 2);
    check("valid_width", v_max, 1);
    compare_model("write1");

    // Backpressure: valid/addr/data held until ready.
    cfgReady = 1'b0;
    f = 32'h15AB_CDEF;
    send_frame(f, 0);
    model_frame(f, 0);
    repeat (22) @(posedge clk);
    #1;
    check("bp_valid", cfgValid, 1);
    check("bp_addr", cfgAddr, 4'h5);
    check("bp_data", cfgData, 24'hABCDEF);
    cfgReady = 1'b1;
    @(posedge clk); #1;
    check("bp_drop", cfgValid, 0);
    check("bp_stable", stab_viol, 0);
    wait_idle(0);
    compare_model("backpressure");

    // Overrun: second frame completes while the first write is pending.
    cfgReady = 1'b0;
    f = 32'h1712_3400;
    send_frame(f, 0);
    model_frame(f, 0);
    f = 32'h1999_9999;
    send_frame(f, 0);
    model_frame(f, 1);
    repeat (3) @(posedge clk);
    #1;
    check("ovr_err", errorCount, exp_err);
    check("ovr_addr", cfgAddr, 4'h7);
    cfgReady = 1'b1;
    wait_idle(0);
    compare_model("overrun");

    // Commit frame.
    f = 32'h2000_0000;
    send_frame(f, 1);
    model_frame(f, 0);
    wait_idle(0);
    check("commit_width", c_max, 1);
    compare_model("commit");

    // Abort mid-frame, then a clean frame.
    for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)), 0);
    pulse_abort(1'b0);
    bump_err();
    f = 32'h1300_00FF;
    send_frame(f, 0);
    model_frame(f, 0);
    wait_idle(0);
    compare_model("abort12");

    // Aborts at a frame boundary, one with a coincident bit that must be discarded.
    pulse_abort(1'b0);
    pulse_abort(1'b1);
    f = 32'h1400_ABCD;
    send_frame(f, 0);
    model_frame(f, 0);
    wait_idle(0);
    compare_model("abort_boundary");

    // Unknown command.
    f = 32'h5123_4567;
    send_frame(f, 0);
    model_frame(f, 0);
    wait_idle(0);
    compare_model("badcmd");

    // Randomized frames against the reference model.
    for (int n = 0; n < 20; n++) begin
      int r;
      r   = int'($urandom_range(0, 9));
      rnd = $urandom();
      cmd = (r < 5) ? 4'h1 : (r < 8) ? 4'h2 : rnd[31:28];
      f   = {cmd, rnd[27:0]};
      cfgReady = 1'($urandom_range(0, 1));
      send_frame(f, int'($urandom_range(0, 2)));
      model_frame(f, 0);
      wait_idle(1);
    end
    cfgReady = 1'b1;
    compare_model("random");

    // Partial frame left idle.
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    repeat (1023) @(posedge clk);
    #1;
    check("tmo_busy_before", busy, 1);
    @(posedge clk); #1;
`ifdef SPI_FRAME_TIMEOUT_EN
    check("tmo_busy_after", busy, 0);
    bump_err();
`else
    check("tmo_busy_persist", busy, 1);
    pulse_abort(1'b0);
    bump_err();
`endif
    check("tmo_err", errorCount, exp_err);
    f = 32'h1B00_0001;
    send_frame(f, 0);
    model_frame(f, 0);
    wait_idle(0);
    compare_model("timeout");

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      send_bit(1'b0, 0);
      pulse_abort(1'b0);
      bump_err();
    end
    check("sat_err", errorCount, 255);
    check("sat_busy", busy, 0);

    // Reset while a write is pending and a frame is partial.
    cfgReady = 1'b0;
    send_frame(32'h1C00_1234, 0);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 0);
    check("pre_rst_valid", cfgValid, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_addr", cfgAddr, 0);
    check("mid_rst_data", cfgData, 0);
    check("mid_rst_valid", cfgValid, 0);
    check("mid_rst_commit", commitPulse, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", errorCount, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_frame_controller.md
Name: spi_frame_controller

Overview:
- Consumes the per-bit strobe stream (serialOut/serialEn) from the SPI slave front end in the clk domain.
- Assembles 32-bit frames MSB-first and decodes each frame into a configuration command.
- Sequences each write onto the design's configuration bus with a valid/ready handshake, and raises a commit pulse.
- Sits between SPISlave and the configuration register consumers; it is the only master of the config bus.

Parameters:
- FRAME_WIDTH, 32, bits per SPI frame.
- ADDR_WIDTH, 4, config register address width (frame bits [27:24]).
- DATA_WIDTH, 24, config data width (frame bits [23:0]).
- TIMEOUT_CYCLES, 1024, idle clk cycles allowed mid-frame before the partial frame is discarded.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- serialOut  input  1  data bit; valid only while serialEn=1.
- serialEn  input  1  one-clk strobe per received bit.
- frameAbort  input  1  synchronous pulse (CS released); discards any partial frame.
- cfgAddr  output  ADDR_WIDTH  config write address.
- cfgData  output  DATA_WIDTH  config write data.
- cfgValid  output  1  write request.
- cfgReady  input  1  consumer accepts when cfgValid&&cfgReady.
- commitPulse  output  1  one-clk pulse on a commit command.
- busy  output  1  high while a partial frame or a pending word exists.
- errorCount  output  8  saturating count of bad/overrun/timed-out frames.

Behaviour:
- Reset values: cfgAddr=0, cfgData=0, cfgValid=0, commitPulse=0, busy=0, errorCount=0. Shift register, bit counter, holding register and timeout counter are all cleared.
- Shifter:
  - On each serialEn, shiftReg <= {shiftReg[30:0], serialOut} and bitCount++.
  - When bitCount reaches 31 and serialEn=1, the completed word goes to the holding register (holdValid=1) in the same cycle and bitCount wraps to 0.
  - The shifter never stalls.
- Frame format: [31:28] cmd, [27:24] addr, [23:0] data.
  - cmd 4'h1 = WRITE.
  - cmd 4'h2 = COMMIT; addr and data are ignored.
  - Any other cmd = error: errorCount+1, frame dropped.
- FSM states IDLE, DECODE, WRITE, COMMIT:
  - IDLE -> DECODE when holdValid=1.
  - DECODE (1 cycle): WRITE cmd -> WRITE, loading cfgAddr/cfgData and setting cfgValid=1. COMMIT cmd -> COMMIT. Bad cmd -> IDLE with an error.
  - WRITE: hold cfgValid, cfgAddr and cfgData stable until cfgReady=1. In the accepting cycle go to IDLE, drop cfgValid next cycle, and clear holdValid.
  - COMMIT: commitPulse=1 for exactly one cycle, clear holdValid, -> IDLE.
- Latency: last bit strobe to cfgValid=1 is 2 clk cycles when the FSM is idle.
- Overrun: if a new word completes while holdValid=1, the new word is dropped, errorCount+1, and the held word is unaffected.
- frameAbort:
  - Clears shiftReg and bitCount.
  - Does not affect the holding register or an in-flight WRITE.
  - If it coincides with a serialEn, the abort wins and the bit is discarded.
  - If bitCount≠0 at the abort, errorCount+1; an abort at a frame boundary is not an error.
- Timeout: a counter runs while bitCount≠0 and resets on each serialEn. At TIMEOUT_CYCLES it acts as frameAbort with an error.
- errorCount saturates at 255. Multiple error sources in one cycle count as one increment.
- busy = (bitCount≠0) || holdValid || (state≠IDLE).
- A reset asserted mid-frame or mid-WRITE returns every output to its reset value on the next edge.

Optional Feature:
- SPI_FRAME_TIMEOUT_EN
- Defined: the timeout counter and timeout error are present as specified.
- Undefined: no counter is synthesised; a partial frame persists until frameAbort or completion, and TIMEOUT_CYCLES is unused.

Decomposition:
- Package spi_ctrl_pkg holds:
  - the cmd enum (CMD_WRITE=4'h1, CMD_COMMIT=4'h2);
  - the FSM state enum;
  - frame field bit-position localparams;
  - the packed frame struct {cmd, addr, data}.
- One sub-module, spi_frame_shifter, holds the shift register, bit counter, timeout and abort logic. It outputs wordValid (1-cycle) and word. The FSM, holding register and error counter stay in the top module.

Test Plan:
- Stream frame 32'h1A_123456 at 8 MHz with cfgReady=1 -> single cfgValid cycle with cfgAddr=4'hA and cfgData=24'h123456, 2 cycles after the last strobe; errorCount=0.
- Hold cfgReady=0 for 20 cycles after a WRITE -> cfgValid/cfgAddr/cfgData stay stable; accepted on the first ready cycle.
- Send a WRITE with cfgReady=0, then a second full frame before ready -> second frame dropped, errorCount=1, first write still delivered.
- Send frame 32'h2000_0000 -> commitPulse high for exactly one cycle and no cfgValid.
- Send 12 bits then frameAbort, then a full frame 32'h1300_00FF -> errorCount=1, then a write with addr=3 and data=24'h0000FF.
- With SPI_FRAME_TIMEOUT_EN defined, send 5 bits then stop for 1024 cycles -> busy falls, errorCount=1. Without the macro -> busy stays high.
